// File: rtl/hourly_chime_gen.sv
// Hour/half-hour chime generator: strikes N square-wave tone bursts on each hour mark,
// optionally one strike at :30, with an optional (possibly midnight-wrapping) quiet window.
module hourly_chime_gen #(
    parameter int unsigned TONE_HALF    = 20000,
    parameter int unsigned STRIKE_ON    = 50_000_000,
    parameter int unsigned STRIKE_GAP   = 50_000_000,
    parameter bit          MODE_24H     = 1'b0,
    parameter bit          HALF_HOUR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       on,
    input  logic [5:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       quiet_en,
    input  logic [5:0] quiet_start,
    input  logic [5:0] quiet_end,
    output logic       speak,
    output logic       busy,
    output logic [4:0] strikes_left
);

    localparam int unsigned ToneW    = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int unsigned PhaseMax = (STRIKE_ON > STRIKE_GAP) ? STRIKE_ON : STRIKE_GAP;
    localparam int unsigned PhaseW   = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;

    localparam logic [ToneW-1:0]  ToneLast = ToneW'(TONE_HALF - 1);
    localparam logic [PhaseW-1:0] OnLast   = PhaseW'(STRIKE_ON - 1);
    localparam logic [PhaseW-1:0] GapLast  = PhaseW'(STRIKE_GAP - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StGap
    } state_e;

    state_e              state_q;
    logic [ToneW-1:0]    tone_cnt_q;
    logic [PhaseW-1:0]   phase_cnt_q;
    logic                at_mark_q;

    logic       hour_mark;
    logic       half_mark;
    logic       mark_now;
    logic       hour_valid;
    logic       quiet_active;
    logic       trigger;
    logic [4:0] hour12;
    logic [4:0] n_strikes;

    always_comb begin
        hour_mark  = (min == 6'd0) && (sec == 6'd0);
        half_mark  = HALF_HOUR_EN && (min == 6'd30) && (sec == 6'd0);
        mark_now   = hour_mark || half_mark;
        hour_valid = (hour <= 6'd23);

        // Window wraps past midnight when start > end; start == end means empty.
        quiet_active = 1'b0;
        if (quiet_en) begin
            if (quiet_start < quiet_end) begin
                quiet_active = (hour >= quiet_start) && (hour < quiet_end);
            end else if (quiet_start > quiet_end) begin
                quiet_active = (hour >= quiet_start) || (hour < quiet_end);
            end
        end

        hour12 = 5'((hour >= 6'd12) ? (hour - 6'd12) : hour);

        if (!hour_mark) begin
            n_strikes = 5'd1;
        end else if (MODE_24H) begin
            n_strikes = (hour == 6'd0) ? 5'd24 : hour[4:0];
        end else begin
            n_strikes = (hour12 == 5'd0) ? 5'd12 : hour12;
        end

        // Edge detect on the mark so a held time fires once and reset never fires.
        trigger = on && (state_q == StIdle) && !at_mark_q && mark_now &&
                  hour_valid && !quiet_active;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            speak        <= 1'b0;
            busy         <= 1'b0;
            strikes_left <= 5'd0;
            tone_cnt_q   <= '0;
            phase_cnt_q  <= '0;
            at_mark_q    <= 1'b1;
        end else begin
            at_mark_q <= mark_now;
            case (state_q)
                StIdle: begin
                    if (trigger) begin
                        state_q      <= StOn;
                        speak        <= 1'b1;
                        busy         <= 1'b1;
                        strikes_left <= n_strikes;
                        tone_cnt_q   <= '0;
                        phase_cnt_q  <= '0;
                    end
                end

                StOn: begin
                    if (!on) begin
                        state_q      <= StIdle;
                        speak        <= 1'b0;
                        busy         <= 1'b0;
                        strikes_left <= 5'd0;
                        tone_cnt_q   <= '0;
                        phase_cnt_q  <= '0;
                    end else if (phase_cnt_q == OnLast) begin
                        speak       <= 1'b0;
                        tone_cnt_q  <= '0;
                        phase_cnt_q <= '0;
                        if (strikes_left == 5'd1) begin
                            state_q      <= StIdle;
                            busy         <= 1'b0;
                            strikes_left <= 5'd0;
                        end else begin
                            state_q      <= StGap;
                            strikes_left <= strikes_left - 5'd1;
                        end
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 1'b1;
                        if (tone_cnt_q == ToneLast) begin
                            tone_cnt_q <= '0;
                            speak      <= ~speak;
                        end else begin
                            tone_cnt_q <= tone_cnt_q + 1'b1;
                        end
                    end
                end

                StGap: begin
                    if (!on) begin
                        state_q      <= StIdle;
                        speak        <= 1'b0;
                        busy         <= 1'b0;
                        strikes_left <= 5'd0;
                        tone_cnt_q   <= '0;
                        phase_cnt_q  <= '0;
                    end else if (phase_cnt_q == GapLast) begin
                        state_q     <= StOn;
                        speak       <= 1'b1;
                        tone_cnt_q  <= '0;
                        phase_cnt_q <= '0;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q      <= StIdle;
                    speak        <= 1'b0;
                    busy         <= 1'b0;
                    strikes_left <= 5'd0;
                    tone_cnt_q   <= '0;
                    phase_cnt_q  <= '0;
                end
            endcase
        end
    end

endmodule
